// File: rtl/neuron_mac_sequencer_if.sv
// Memory-side bundle of the MAC sequencer: operand read ports and activation write port.
// master = sequencer (issues addresses, writes results); slave = memories/consumer.
interface neuron_mac_sequencer_if #(
  parameter int N_IN     = 768,
  parameter int N_NEURON = 64,
  parameter int DW       = 16
);
  localparam int IW = $clog2(N_IN);
  localparam int NW = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;

  logic [IW-1:0]    data_addr;
  logic [DW-1:0]    data_rdata;
  logic [NW+IW-1:0] weight_addr;
  logic [DW-1:0]    weight_rdata;
  logic [NW-1:0]    bias_addr;
  logic [DW-1:0]    bias_rdata;
  logic             out_we;
  logic [NW-1:0]    out_addr;
  logic [DW-1:0]    out_wdata;

  modport master (
    output data_addr, weight_addr, bias_addr, out_we, out_addr, out_wdata,
    input  data_rdata, weight_rdata, bias_rdata
  );

  modport slave (
    input  data_addr, weight_addr, bias_addr, out_we, out_addr, out_wdata,
    output data_rdata, weight_rdata, bias_rdata
  );
endinterface

// File: rtl/neuron_mac_sequencer.sv
// Runs one dense layer: per neuron, N_IN MACs over 1-cycle-latency memories, then bias, saturate, ReLU, write.
// Latency N_IN+2 cycles per neuron, N_NEURON*(N_IN+2)+1 from start to done; no backpressure, abort cancels.
module neuron_mac_sequencer #(
  parameter int N_IN     = 768,
  parameter int N_NEURON = 64,
  parameter int DW       = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  neuron_mac_sequencer_if.master         m
);
  localparam int IW = $clog2(N_IN);
  localparam int NW = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
  localparam int AW = 2*DW + IW;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);
  localparam logic [NW-1:0] LAST_NEU = NW'(N_NEURON - 1);

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, WRITE, DONE} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          index;
  logic [NW-1:0]          neuron;
  logic signed [AW-1:0]   acc;
  logic                   rvalid;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   acc_sh;
  logic signed [AW:0]     y;
  logic [DW-1:0]          y_sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (index == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   state_nxt = WRITE;
      WRITE:   state_nxt = (neuron == LAST_NEU) ? DONE : ACCUM;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && abort) state_nxt = IDLE;
  end

  assign prod = $signed(m.data_rdata) * $signed(m.weight_rdata);

  // rvalid marks the cycle in which the operands for last cycle's address arrive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index  <= '0;
      neuron <= '0;
      acc    <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= (state == ACCUM) && !abort;
      if (state == IDLE) begin
        if (start) begin
          index  <= '0;
          neuron <= '0;
          acc    <= '0;
        end
      end else if (abort) begin
        index  <= '0;
        neuron <= '0;
        acc    <= '0;
      end else begin
        if (rvalid) acc <= acc + {{IW{prod[2*DW-1]}}, prod};
        case (state)
          ACCUM: index <= (index == LAST_IDX) ? '0 : index + 1'b1;
          WRITE: begin
            if (neuron != LAST_NEU) begin
              neuron <= neuron + 1'b1;
              index  <= '0;
              acc    <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Full-width sum of rescaled acc and bias; clamping happens only on this final value
  assign acc_sh = acc >>> 8;
  assign y      = {acc_sh[AW-1], acc_sh} + {{(AW+1-DW){m.bias_rdata[DW-1]}}, m.bias_rdata};

  always_comb begin
    y_sat = '0;
    if (y[AW])                    y_sat = '0;
    else if (y[AW-1:DW-1] != '0)  y_sat = {1'b0, {(DW-1){1'b1}}};
    else                          y_sat = y[DW-1:0];
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE) && !abort;
  assign m.out_we    = (state == WRITE) && !abort;
  assign m.out_addr  = neuron;
  assign m.out_wdata = m.out_we ? y_sat : '0;
  assign m.data_addr   = index;
  assign m.weight_addr = {neuron, index};
  assign m.bias_addr   = neuron;
endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench for neuron_mac_sequencer with N_IN=4, N_NEURON=2 and synchronous-read memory models.
module tb_neuron_mac_sequencer;
  logic clk = 1'b0;
  logic reset, start, abort, busy, done;

  neuron_mac_sequencer_if #(.N_IN(4), .N_NEURON(2), .DW(16)) mif ();

  neuron_mac_sequencer #(.N_IN(4), .N_NEURON(2), .DW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .m     (mif.master)
  );

  always #5 clk = ~clk;

  logic [15:0] dmem [4];
  logic [15:0] wmem [8];
  logic [15:0] bmem [2];

  always @(posedge clk) begin
    mif.data_rdata   <= dmem[mif.data_addr];
    mif.weight_rdata <= wmem[mif.weight_addr];
    mif.bias_rdata   <= bmem[mif.bias_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          idle_nz = 0;
  logic [0:0]  wr_addr_q [$];
  logic [15:0] wr_data_q [$];

  always @(negedge clk) begin
    if (mif.out_we) begin
      wr_addr_q.push_back(mif.out_addr);
      wr_data_q.push_back(mif.out_wdata);
    end else if (mif.out_wdata != 16'h0) begin
      idle_nz++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
  endtask

  task automatic fill(input logic [15:0] d, input logic [15:0] w, input logic [15:0] b);
    for (int i = 0; i < 4; i++) dmem[i] = d;
    for (int i = 0; i < 8; i++) wmem[i] = w;
    for (int i = 0; i < 2; i++) bmem[i] = b;
  endtask

  // extra_start >= 0 re-pulses start that many cycles into the layer
  task automatic run_layer(input string tag, input int extra_start,
                           input logic [15:0] e0, input logic [15:0] e1, input bit chk_lat);
    int start_cyc;
    bit seen;
    clear_log();
    step();
    start_cyc = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      start = (i == extra_start);
      if (done_cnt > 0) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    start = 1'b0;
    if (!seen) check({tag, "_done_timeout"}, 0, 1);
    repeat (3) step();
    check({tag, "_nwrites"}, wr_addr_q.size(), 2);
    check({tag, "_ndone"}, done_cnt, 1);
    if (chk_lat) check({tag, "_latency"}, done_cyc - start_cyc, 13);
    if (wr_addr_q.size() == 2) begin
      check({tag, "_addr0"}, wr_addr_q[0], 0);
      check({tag, "_data0"}, wr_data_q[0], e0);
      check({tag, "_addr1"}, wr_addr_q[1], 1);
      check({tag, "_data1"}, wr_data_q[1], e1);
    end
    check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    fill(16'h0100, 16'h0080, 16'h0000);
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", mif.out_we, 0);
    check("rst_daddr", mif.data_addr, 0);
    check("rst_waddr", mif.weight_addr, 0);
    check("rst_baddr", mif.bias_addr, 0);
    check("rst_wdata", mif.out_wdata, 0);
    step();
    reset = 1'b0;
    step();

    // 4 * (1.0*0.5) = 2.0
    run_layer("basic", -1, 16'h0200, 16'h0200, 1'b1);

    // per-element data and per-neuron weights/bias exercise the addressing
    for (int i = 0; i < 4; i++) dmem[i] = 16'((i + 1) * 256);
    for (int i = 0; i < 4; i++) wmem[i] = 16'h0100;
    for (int i = 0; i < 4; i++) wmem[4 + i] = 16'(i * 64);
    bmem[0] = 16'h0010;
    bmem[1] = 16'hFFF0;
    run_layer("varied", -1, 16'h0A10, 16'h04F0, 1'b1);

    fill(16'h0100, 16'hFF00, 16'h0100);
    run_layer("relu", -1, 16'h0000, 16'h0000, 1'b0);

    fill(16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_layer("sat", -1, 16'h7FFF, 16'h7FFF, 1'b0);

    fill(16'h0100, 16'h0080, 16'h0000);
    run_layer("restart", 5, 16'h0200, 16'h0200, 1'b1);

    // start in the DONE cycle is ignored; start in the following IDLE cycle is taken
    clear_log();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      step();
    end
    check("done_seen", done, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_in_done_ignored", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_after_done_taken", busy, 1);
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      step();
    end
    check("b2b_idle", busy, 0);

    // abort during ACCUM of neuron 1
    step();
    clear_log();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    check("abort_pre_busy", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    repeat (20) step();
    check("abort_nwrites", wr_addr_q.size(), 1);
    check("abort_ndone", done_cnt, 0);

    // asynchronous reset between edges during ACCUM of neuron 1
    clear_log();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_we", mif.out_we, 0);
    check("arst_daddr", mif.data_addr, 0);
    check("arst_waddr", mif.weight_addr, 0);
    check("arst_baddr", mif.bias_addr, 0);
    step();
    reset = 1'b0;
    repeat (10) step();
    check("arst_no_resume", busy, 0);
    check("arst_nwrites", wr_addr_q.size(), 1);
    check("arst_ndone", done_cnt, 0);
    run_layer("post_rst", -1, 16'h0200, 16'h0200, 1'b1);

    check("idle_wdata_zero", idle_nz, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
